// File: rtl/guess_pkg.sv
// Shared types and widths for the guessing-game round sequencer.
// Also holds the saturating score increment used by the round controller.
package guess_pkg;

    localparam int SCORE_W = 4;
    localparam int LIVES_W = 2;
    localparam int TIME_W  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        PLAY   = 3'd2,
        RESULT = 3'd3,
        OVER   = 3'd4
    } game_state_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        if (v == {SCORE_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 4'd1;
        end
    endfunction

endpackage

// File: rtl/guess_round_ctrl_tick_gen.sv
// Once-per-second prescaler: counts 0..TICKS_PER_SEC-1 while enabled.
// It strobes tick on the last count; clr forces the count back to 0 and wins over en.
module tick_gen #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] count_r;

    // Prescaler count register with wrap on the last count
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            if (count_r == LAST) begin
                count_r <= {CNT_W{1'b0}};
            end else begin
                count_r <= count_r + CNT_W'(1'b1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign tick = en & ~clr & (count_r == LAST);

endmodule

// File: rtl/guess_round_ctrl.sv
// Round sequencer for the button guessing game: arms guess_FSM one round at a time,
// times each round, and keeps score, lives and the game-over verdict.
module guess_round_ctrl
    import guess_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int ROUND_SECS    = 9,
    parameter int LIVES         = 3,
    parameter int WIN_TARGET    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               win,
    input  logic               lose,
    output logic               fsm_rst,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic [TIME_W-1:0]  time_left,
    output logic               game_over,
    output logic               game_won
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [TIME_W-1:0]  ROUND_INIT = TIME_W'(ROUND_SECS);
    localparam logic [SCORE_W-1:0] TARGET     = SCORE_W'(WIN_TARGET);

    game_state_t        state_r, next_state_s;
    logic               start_q_r, start_edge_s;
    logic               tick_s, presc_clr_s, presc_en_s;
    logic [SCORE_W-1:0] score_r, score_s;
    logic [LIVES_W-1:0] lives_r, lives_s;
    logic [TIME_W-1:0]  time_left_r, time_left_s;
    logic               fsm_rst_r, fsm_rst_s;
    logic               game_over_r, game_over_s;
    logic               game_won_r, game_won_s;

    assign start_edge_s = start & ~start_q_r;

    tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr_s),
        .en   (presc_en_s),
        .tick (tick_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_edge_s) next_state_s = ARM;
                else              next_state_s = IDLE;
            end
            ARM: begin
                next_state_s = PLAY;
            end
            PLAY: begin
                if (win || lose || (time_left_r == {TIME_W{1'b0}})) next_state_s = RESULT;
                else                                                next_state_s = PLAY;
            end
            RESULT: begin
                if (!tick_s)                          next_state_s = RESULT;
                else if (score_r == TARGET)           next_state_s = OVER;
                else if (lives_r == {LIVES_W{1'b0}})  next_state_s = OVER;
                else                                  next_state_s = ARM;
            end
            OVER: begin
                if (start_edge_s) next_state_s = ARM;
                else              next_state_s = OVER;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output and counter update decode; flags follow the next state so they stay registered
    always_comb begin
        score_s     = score_r;
        lives_s     = lives_r;
        time_left_s = time_left_r;
        game_won_s  = game_won_r;
        presc_clr_s = 1'b0;
        presc_en_s  = 1'b0;
        fsm_rst_s   = (next_state_s != PLAY);
        game_over_s = (next_state_s == OVER);
        case (state_r)
            IDLE, OVER: begin
                if (start_edge_s) begin
                    score_s    = {SCORE_W{1'b0}};
                    lives_s    = LIVES_INIT;
                    game_won_s = 1'b0;
                end else begin
                    score_s    = score_r;
                end
            end
            ARM: begin
                time_left_s = ROUND_INIT;
                presc_clr_s = 1'b1;
            end
            PLAY: begin
                presc_en_s = 1'b1;
                if (win) begin
                    score_s     = sat_inc(score_r);
                    presc_clr_s = 1'b1;
                end else if (lose || (time_left_r == {TIME_W{1'b0}})) begin
                    if (lives_r != {LIVES_W{1'b0}}) lives_s = lives_r - 2'd1;
                    else                            lives_s = {LIVES_W{1'b0}};
                    presc_clr_s = 1'b1;
                end else if (tick_s) begin
                    time_left_s = time_left_r - 4'd1;
                end else begin
                    time_left_s = time_left_r;
                end
            end
            RESULT: begin
                presc_en_s = 1'b1;
                if (next_state_s == OVER) game_won_s = (score_r == TARGET);
                else                      game_won_s = game_won_r;
            end
            default: begin
                presc_en_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q_r   <= 1'b0;
            score_r     <= {SCORE_W{1'b0}};
            lives_r     <= LIVES_INIT;
            time_left_r <= ROUND_INIT;
            fsm_rst_r   <= 1'b1;
            game_over_r <= 1'b0;
            game_won_r  <= 1'b0;
        end else begin
            start_q_r   <= start;
            score_r     <= score_s;
            lives_r     <= lives_s;
            time_left_r <= time_left_s;
            fsm_rst_r   <= fsm_rst_s;
            game_over_r <= game_over_s;
            game_won_r  <= game_won_s;
        end
    end

    assign fsm_rst   = fsm_rst_r;
    assign score     = score_r;
    assign lives     = lives_r;
    assign time_left = time_left_r;
    assign game_over = game_over_r;
    assign game_won  = game_won_r;

endmodule

// File: doc/guess_round_ctrl.md
# guess_round_ctrl

Round sequencer for the button guessing game: it owns the reset of `guess_FSM`, arms one guessing round at a time, and times each round. It converts the FSM's `win`/`lose` levels into a running score and a lives count, and declares game over. It sits in `guessing_game` between the debounced buttons and `guess_FSM`, and drives the score/timer display and the LEDs.

## Interface
- `TICKS_PER_SEC`, 100_000_000: `clk` cycles per timer second; legal range ≥2.
- `ROUND_SECS`, 9: seconds allowed per round; legal range 1..15.
- `LIVES`, 3: lives at game start; legal range 1..3.
- `WIN_TARGET`, 5: round wins needed to win the game; legal range 1..15.

Ports:
- `clk` in 1: system clock. The block has one clock.
- `rst` in 1: synchronous, active-high reset, tied to `btnC`.
- `start` in 1: debounced start button level. Only its rising edge is used.
- `win` in 1: win level from `guess_FSM`.
- `lose` in 1: lose level from `guess_FSM`.
- `fsm_rst` out 1: synchronous reset driven to `guess_FSM`.
- `score` out 4: rounds won.
- `lives` out 2: lives remaining.
- `time_left` out 4: seconds remaining in the current round.
- `game_over` out 1: high in OVER.
- `game_won` out 1: high in OVER when the score target was reached.

## Operation
- States: IDLE, ARM, PLAY, RESULT, OVER.
- Start edge detection: `start_q` registers `start`. A start edge is `start & ~start_q`.
- IDLE:
  - `fsm_rst` = 1.
  - On a start edge: `score` ← 0, `lives` ← LIVES, go to ARM.
- ARM (exactly 1 cycle):
  - `fsm_rst` = 1.
  - `time_left` ← ROUND_SECS; prescaler ← 0.
  - Go to PLAY.
- PLAY:
  - `fsm_rst` = 0.
  - Priority, evaluated every cycle:
    1. `win`=1: `score` +1 (saturates at 15), go to RESULT.
    2. else `lose`=1 or `time_left`==0: `lives` −1 (floor 0), go to RESULT.
    3. else on a prescaler tick: `time_left` −1.
- RESULT:
  - `fsm_rst` = 1, which clears `guess_FSM` so `win`/`lose` drop.
  - Hold for TICKS_PER_SEC cycles; the prescaler is cleared on entry.
  - Then the first matching condition applies:
    - `score`==WIN_TARGET: go to OVER with `game_won` ← 1.
    - else `lives`==0: go to OVER with `game_won` ← 0.
    - else go to ARM.
- OVER:
  - `fsm_rst` = 1.
  - `score` and `lives` are frozen.
  - On a start edge: `score` ← 0, `lives` ← LIVES, `game_won` ← 0, go to ARM.
- Start edges in ARM, PLAY and RESULT are ignored.
- `win` and `lose` are ignored outside PLAY.
- Simultaneous events in PLAY: if `win` and `lose` are both high, or `win` is high on the cycle `time_left` is 0, the round counts as a win.
- `rst` mid-round: all registers return to their reset values on the next edge. No score or lives are retained.

## Timing
- Reset values:
  - state = IDLE
  - `fsm_rst` = 1
  - `score` = 0
  - `lives` = LIVES
  - `time_left` = ROUND_SECS
  - `game_over` = 0
  - `game_won` = 0
  - `start_q` = 0
- All outputs are registered, or decoded directly from the state register.
- Start edge latency: the edge is seen at edge k. ARM is active in cycle k+1 and PLAY in cycle k+2.
- Prescaler:
  - Counts 0..TICKS_PER_SEC−1 in PLAY and RESULT.
  - Asserts `tick` for one cycle when the count equals TICKS_PER_SEC−1, then wraps to 0.
- Win latency: a `win` seen in PLAY cycle n updates `score` and enters RESULT at n+1. `fsm_rst` is high from n+1.
- Timeout: `time_left` reaches 0 after ROUND_SECS·TICKS_PER_SEC PLAY cycles. The life is lost on the following cycle.
- RESULT lasts exactly TICKS_PER_SEC cycles.
- `game_over` is high if and only if state == OVER.

## Structure
- Package `guess_pkg` holds:
  - `game_state_t`, a 3-bit enum {IDLE, ARM, PLAY, RESULT, OVER};
  - the width constants `SCORE_W`=4, `LIVES_W`=2, `TIME_W`=4.
- Sub-module `tick_gen #(TICKS_PER_SEC)` with ports `clk`, `rst`, `clr`, `en` and `tick`.
  - It is the sole prescaler.
  - `clr` takes priority over `en`.
- The FSM, counters and edge detector live in `guess_round_ctrl`.

## Test plan
All scenarios use TICKS_PER_SEC=4, ROUND_SECS=2, LIVES=2, WIN_TARGET=2.

1. Reset, then a start pulse:
   - The state sequence is IDLE→ARM→PLAY.
   - `fsm_rst` reads 1,1,0.
   - Outputs are `score`=0, `lives`=2, `time_left`=2.
2. Idle timeout:
   - `time_left` reads 2→1 after 4 PLAY cycles and 1→0 after 8.
   - On the 9th PLAY cycle `lives` becomes 1 and the state is RESULT.
   - After 4 RESULT cycles the state returns to ARM.
3. Win twice:
   - Raise `win` during PLAY in two consecutive rounds.
   - `score` reads 1 and then 2.
   - After the second RESULT: `game_over`=1 and `game_won`=1.
   - A start edge restores `score`=0 and `lives`=2.
4. Lose twice:
   - `lives` reads 1, then 0.
   - The game ends in OVER with `game_won`=0.
   - Further `win` pulses leave `score` unchanged.
5. Simultaneous events:
   - Raise `win` and `lose` together in PLAY: `score`+1, `lives` unchanged.
   - Raise `win` on the cycle `time_left`==0: counts as a win.
6. `rst` asserted mid-PLAY with `score`=1:
   - Next cycle the state is IDLE, `score`=0, `lives`=2 and `fsm_rst`=1.
   - A start pulse in PLAY is ignored.
